// File: rtl/tinymem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tinymem_arbiter_pkg
// Shared types for the two-requester memory arbiter:
//   arb_state_t - arbiter FSM state (idle / downstream request / wait response)
//   mem_req_t   - one memory request (address, write flag, data, strobes)
//   pick_m1     - 2-way round-robin pick between fetch (m0) and data (m1)
// -----------------------------------------------------------------------------
package tinymem_arbiter_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0]   addr;
        logic                    wr;
        logic [MEM_DATA_W-1:0]   wdata;
        logic [MEM_DATA_W/8-1:0] wstrb;
    } mem_req_t;

    // m1 wins when it is the only requester, or on a tie when m0 had the
    // previous grant (last == 0). Otherwise m0 wins.
    function automatic logic pick_m1(input logic v0, input logic v1, input logic last);
        return v1 & (~v0 | ~last);
    endfunction

endpackage

// File: rtl/tinymem_arbiter_if.sv
// -----------------------------------------------------------------------------
// tinymem_arbiter_if
// Simple valid/ready request bus with a single-pulse response.
// Used for both requester ports (arbiter is the slave) and the downstream
// memory port (arbiter is the master).
//   valid/addr/wr/wdata/wstrb : request, driven by the master
//   ready                     : request accepted this cycle, driven by the slave
//   rvalid/rdata/err          : response pulse, read data, timeout error
// -----------------------------------------------------------------------------
interface tinymem_arbiter_if
    import tinymem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);

    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output valid, addr, wr, wdata, wstrb,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  valid, addr, wr, wdata, wstrb,
        output ready, rvalid, rdata, err
    );

endinterface

// File: rtl/tinymem_arbiter.sv
// -----------------------------------------------------------------------------
// tinymem_arbiter
// Shares one downstream memory port between instruction fetch (m0) and data
// access (m1). Round-robin on ties, one transaction in flight at a time,
// response routed back to the granted requester, and a watchdog that
// completes a stuck transaction with err=1.
// Ports:
//   clk_i    - clock
//   reset_i  - asynchronous active-low reset
//   m0, m1   - requester ports (slave side of tinymem_arbiter_if)
//   s        - downstream memory port (master side of tinymem_arbiter_if)
// Parameters:
//   ADDR_W, DATA_W - bus widths (must match the package request struct)
//   TIMEOUT        - cycles allowed in REQ+RESP before error completion,
//                    0 disables the watchdog
// -----------------------------------------------------------------------------
module tinymem_arbiter
    import tinymem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic               clk_i,
    input  logic               reset_i,
    tinymem_arbiter_if.slave   m0,
    tinymem_arbiter_if.slave   m1,
    tinymem_arbiter_if.master  s
);

    // The latched request is held in the package struct, so the bus widths
    // must agree with it.
    if (ADDR_W != MEM_ADDR_W || DATA_W != MEM_DATA_W) begin : g_width_check
        $error("tinymem_arbiter: ADDR_W/DATA_W must match tinymem_arbiter_pkg");
    end

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t       state_q;
    logic             grant_q;   // 0 = m0, 1 = m1 owns the in-flight transaction
    logic             last_q;    // previous grant, drives the tie-break
    logic [CNT_W-1:0] wait_cnt;
    mem_req_t         req_q;

    mem_req_t m0_req;
    mem_req_t m1_req;
    logic     sel_m1;
    logic     capture;
    logic     done_ok;
    logic     timeout;
    logic     finish;

    assign m0_req = '{addr: m0.addr, wr: m0.wr, wdata: m0.wdata, wstrb: m0.wstrb};
    assign m1_req = '{addr: m1.addr, wr: m1.wr, wdata: m1.wdata, wstrb: m1.wstrb};

    assign sel_m1 = pick_m1(m0.valid, m1.valid, last_q);

    // Gated with reset_i so ready stays low while reset is held even though
    // the state register already reads IDLE.
    assign capture = reset_i && (state_q == ARB_IDLE) && (m0.valid || m1.valid);

    assign done_ok = (state_q == ARB_RESP) && s.rvalid;

    // A response arriving in the last allowed cycle wins over the timeout.
    assign timeout = (TIMEOUT > 0) && (state_q != ARB_IDLE) &&
                     (wait_cnt == CNT_LAST) && !done_ok;

    assign finish = done_ok || timeout;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= ARB_IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            wait_cnt <= '0;
            // NOTE: the latched request drives the downstream outputs
            // directly, so it is reset to keep them at zero out of reset.
            req_q    <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (capture) begin
                        req_q    <= sel_m1 ? m1_req : m0_req;
                        grant_q  <= sel_m1;
                        last_q   <= sel_m1;
                        wait_cnt <= '0;
                        state_q  <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (TIMEOUT > 0) wait_cnt <= wait_cnt + CNT_W'(1);
                    if (timeout)      state_q <= ARB_IDLE;
                    else if (s.ready) state_q <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (TIMEOUT > 0) wait_cnt <= wait_cnt + CNT_W'(1);
                    if (finish) state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Downstream request: withdrawn in the cycle the watchdog fires.
    assign s.valid = (state_q == ARB_REQ) && !timeout;
    assign s.addr  = req_q.addr;
    assign s.wr    = req_q.wr;
    assign s.wdata = req_q.wdata;
    assign s.wstrb = req_q.wstrb;

    // Requester side: ready only to the granted port, response only to the
    // port that owns the transaction, data/err qualified by the response.
    assign m0.ready  = capture && !sel_m1;
    assign m1.ready  = capture &&  sel_m1;

    assign m0.rvalid = finish && !grant_q;
    assign m1.rvalid = finish &&  grant_q;

    assign m0.rdata  = (done_ok && !grant_q) ? s.rdata : '0;
    assign m1.rdata  = (done_ok &&  grant_q) ? s.rdata : '0;

    assign m0.err    = timeout && !grant_q;
    assign m1.err    = timeout &&  grant_q;

endmodule

// File: tb/tb_tinymem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tinymem_arbiter
// Directed bench for tinymem_arbiter (TIMEOUT = 8). The bench drives both
// requesters and plays the downstream slave; expected values are hand-derived.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tinymem_arbiter;

    logic clk_i;
    logic reset_i;

    int errors = 0;
    int checks = 0;

    tinymem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
    tinymem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
    tinymem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();

    tinymem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected $finish");
        $fatal(1, "bench time limit");
    end

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_m0(input logic v, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] st);
        m0_bus.valid = v; m0_bus.addr = a; m0_bus.wr = w; m0_bus.wdata = d; m0_bus.wstrb = st;
    endtask

    task automatic set_m1(input logic v, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] st);
        m1_bus.valid = v; m1_bus.addr = a; m1_bus.wr = w; m1_bus.wdata = d; m1_bus.wstrb = st;
    endtask

    task automatic apply_reset;
        reset_i = 1'b0;
        step;
        step;
        reset_i = 1'b1;
    endtask

    // One complete transaction with an immediately ready slave that answers
    // one cycle later. Entered in IDLE with the requester(s) already valid.
    task automatic run_txn(input int g, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [31:0] rsp, input bit hold, input string name);
        logic [1:0]  exp_rdy;
        logic [2:0]  flags;
        logic [31:0] rd;
        exp_rdy = (g == 1) ? 2'b10 : 2'b01;
        #1;
        checks++;
        if ({m1_bus.ready, m0_bus.ready} !== exp_rdy || s_bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_grant: got ready{m1,m0}=%b s_valid=%b, expected %b and 0",
                     name, {m1_bus.ready, m0_bus.ready}, s_bus.valid, exp_rdy);
        end
        step;
        if (!hold) begin
            if (g == 1) m1_bus.valid = 1'b0;
            else        m0_bus.valid = 1'b0;
        end
        s_bus.ready = 1'b1;
        #1;
        checks++;
        if (s_bus.valid !== 1'b1 || s_bus.addr !== addr || s_bus.wr !== wr ||
            s_bus.wdata !== wdata || s_bus.wstrb !== wstrb ||
            {m1_bus.ready, m0_bus.ready} !== 2'b00) begin
            errors++;
            $display("FAIL %s_req: got valid=%b addr=%h wr=%b wdata=%h wstrb=%h rdy=%b, expected 1 %h %b %h %h 00",
                     name, s_bus.valid, s_bus.addr, s_bus.wr, s_bus.wdata, s_bus.wstrb,
                     {m1_bus.ready, m0_bus.ready}, addr, wr, wdata, wstrb);
        end
        step;
        s_bus.ready  = 1'b0;
        s_bus.rvalid = 1'b1;
        s_bus.rdata  = rsp;
        #1;
        flags = (g == 1) ? {m1_bus.rvalid, m1_bus.err, m0_bus.rvalid}
                         : {m0_bus.rvalid, m0_bus.err, m1_bus.rvalid};
        rd    = (g == 1) ? m1_bus.rdata : m0_bus.rdata;
        checks++;
        if (flags !== 3'b100 || (!wr && rd !== rsp)) begin
            errors++;
            $display("FAIL %s_resp: got {rvalid,err,other_rvalid}=%b rdata=%h, expected 100 rdata=%h",
                     name, flags, rd, rsp);
        end
        step;
        s_bus.rvalid = 1'b0;
        s_bus.rdata  = '0;
        #1;
        checks++;
        if ({m1_bus.rvalid, m0_bus.rvalid} !== 2'b00 || m0_bus.rdata !== '0 || m1_bus.rdata !== '0) begin
            errors++;
            $display("FAIL %s_done: got rvalid{m1,m0}=%b rdata0=%h rdata1=%h, expected 00 0 0",
                     name, {m1_bus.rvalid, m0_bus.rvalid}, m0_bus.rdata, m1_bus.rdata);
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b0;
        set_m0(1'b1, 32'h1234, 1'b1, 32'hFFFF_FFFF, 4'hF);
        set_m1(1'b0, '0, 1'b0, '0, 4'h0);
        s_bus.ready = 1'b0; s_bus.rvalid = 1'b1; s_bus.rdata = 32'h5A5A_5A5A; s_bus.err = 1'b0;
        step;
        step;
        checks++;
        if ({s_bus.valid, m0_bus.ready, m0_bus.rvalid, m0_bus.err,
             m1_bus.ready, m1_bus.rvalid, m1_bus.err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got {s_valid,m0 rdy/rv/err,m1 rdy/rv/err}=%b, expected 0000000",
                     {s_bus.valid, m0_bus.ready, m0_bus.rvalid, m0_bus.err,
                      m1_bus.ready, m1_bus.rvalid, m1_bus.err});
        end
        checks++;
        if (s_bus.addr !== '0 || s_bus.wr !== 1'b0 || s_bus.wdata !== '0 || s_bus.wstrb !== '0 ||
            m0_bus.rdata !== '0 || m1_bus.rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wr=%b wdata=%h wstrb=%h rdata0=%h rdata1=%h, expected all 0",
                     s_bus.addr, s_bus.wr, s_bus.wdata, s_bus.wstrb, m0_bus.rdata, m1_bus.rdata);
        end
        set_m0(1'b0, '0, 1'b0, '0, 4'h0);
        s_bus.rvalid = 1'b0; s_bus.rdata = '0;
        reset_i = 1'b1;
        step;
    endtask

    task automatic test_single_read;
        set_m0(1'b1, 32'h100, 1'b0, '0, 4'h0);
        run_txn(0, 32'h100, 1'b0, '0, 4'h0, 32'hDEAD_BEEF, 1'b0, "single");
    endtask

    task automatic test_tie_and_fairness;
        apply_reset;
        set_m0(1'b1, 32'h40, 1'b0, '0, 4'h0);
        set_m1(1'b1, 32'h80, 1'b1, 32'h1234_5678, 4'hF);
        run_txn(0, 32'h40, 1'b0, '0, 4'h0, 32'h0000_0011, 1'b0, "tie0");
        run_txn(1, 32'h80, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b0, "tie1");
        set_m0(1'b1, 32'h200, 1'b0, '0, 4'h0);
        set_m1(1'b1, 32'h300, 1'b0, '0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            run_txn(i % 2, (i % 2 == 1) ? 32'h300 : 32'h200, 1'b0, '0, 4'h0,
                    32'hA0 + 32'(i), 1'b1, "fair");
        end
        set_m0(1'b0, '0, 1'b0, '0, 4'h0);
        set_m1(1'b0, '0, 1'b0, '0, 4'h0);
        step;
    endtask

    task automatic test_slave_stall;
        set_m1(1'b1, 32'h500, 1'b0, '0, 4'h0);
        #1;
        checks++;
        if ({m1_bus.ready, m0_bus.ready} !== 2'b10) begin
            errors++;
            $display("FAIL stall_grant: got ready{m1,m0}=%b, expected 10", {m1_bus.ready, m0_bus.ready});
        end
        step;
        m1_bus.valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s_bus.ready = (k == 5);
            #1;
            checks++;
            if (s_bus.valid !== 1'b1 || s_bus.addr !== 32'h500 || s_bus.wr !== 1'b0 ||
                {m1_bus.ready, m0_bus.ready, m1_bus.rvalid, m0_bus.rvalid} !== 4'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got valid=%b addr=%h rdy/rv=%b, expected 1 00000500 0000",
                         k, s_bus.valid, s_bus.addr,
                         {m1_bus.ready, m0_bus.ready, m1_bus.rvalid, m0_bus.rvalid});
            end
            step;
        end
        s_bus.ready  = 1'b0;
        s_bus.rvalid = 1'b1;
        s_bus.rdata  = 32'hCAFE_F00D;
        #1;
        checks++;
        if (m1_bus.rvalid !== 1'b1 || m1_bus.rdata !== 32'hCAFE_F00D || m1_bus.err !== 1'b0 ||
            m0_bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL stall_resp: got m1 rv=%b rdata=%h err=%b m0 rv=%b, expected 1 cafef00d 0 0",
                     m1_bus.rvalid, m1_bus.rdata, m1_bus.err, m0_bus.rvalid);
        end
        step;
        s_bus.rvalid = 1'b0;
        s_bus.rdata  = '0;
    endtask

    // Slave accepts m1's read but never answers; watchdog fires in the
    // eighth cycle counted from REQ entry (wait_cnt == 7).
    task automatic test_timeout_resp;
        set_m1(1'b1, 32'h600, 1'b0, '0, 4'h0);
        step;
        m1_bus.valid = 1'b0;
        s_bus.ready  = 1'b1;
        step;
        s_bus.ready  = 1'b0;
        for (int c = 1; c < 7; c++) begin
            #1;
            checks++;
            if (m1_bus.rvalid !== 1'b0 || m0_bus.rvalid !== 1'b0) begin
                errors++;
                $display("FAIL tmo_early: wait cycle %0d got rvalid{m1,m0}=%b, expected 00",
                         c, {m1_bus.rvalid, m0_bus.rvalid});
            end
            step;
        end
        set_m0(1'b1, 32'h700, 1'b0, '0, 4'h0);
        #1;
        checks++;
        if (m1_bus.rvalid !== 1'b1 || m1_bus.err !== 1'b1 || m1_bus.rdata !== '0 ||
            m0_bus.rvalid !== 1'b0 || m0_bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL tmo_fire: got m1 rv=%b err=%b rdata=%h m0 rv=%b rdy=%b, expected 1 1 0 0 0",
                     m1_bus.rvalid, m1_bus.err, m1_bus.rdata, m0_bus.rvalid, m0_bus.ready);
        end
        step;
        run_txn(0, 32'h700, 1'b0, '0, 4'h0, 32'h7777_0000, 1'b0, "tmo_next");
    endtask

    // Slave never accepts: request is withdrawn in the timeout cycle.
    task automatic test_timeout_req;
        set_m0(1'b1, 32'h800, 1'b0, '0, 4'h0);
        step;
        m0_bus.valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            #1;
            checks++;
            if (s_bus.valid !== 1'b1 || m0_bus.rvalid !== 1'b0) begin
                errors++;
                $display("FAIL tmo_req_wait: cycle %0d got s_valid=%b m0 rv=%b, expected 1 0",
                         c, s_bus.valid, m0_bus.rvalid);
            end
            step;
        end
        #1;
        checks++;
        if (s_bus.valid !== 1'b0 || m0_bus.rvalid !== 1'b1 || m0_bus.err !== 1'b1 ||
            m0_bus.rdata !== '0 || m1_bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_req_fire: got s_valid=%b m0 rv=%b err=%b rdata=%h m1 rv=%b, expected 0 1 1 0 0",
                     s_bus.valid, m0_bus.rvalid, m0_bus.err, m0_bus.rdata, m1_bus.rvalid);
        end
        step;
        #1;
        checks++;
        if (s_bus.valid !== 1'b0 || m0_bus.rvalid !== 1'b0 || m0_bus.err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_req_idle: got s_valid=%b m0 rv=%b err=%b, expected 0 0 0",
                     s_bus.valid, m0_bus.rvalid, m0_bus.err);
        end
    endtask

    task automatic test_async_reset;
        set_m0(1'b1, 32'h900, 1'b1, 32'h0BAD_CAFE, 4'h3);
        step;
        m0_bus.valid = 1'b0;
        s_bus.ready  = 1'b1;
        step;
        s_bus.ready  = 1'b0;
        s_bus.rvalid = 1'b1;
        s_bus.rdata  = 32'hAA55_AA55;
        #1;
        checks++;
        if (m0_bus.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: got m0 rv=%b, expected 1", m0_bus.rvalid);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if (m0_bus.rvalid !== 1'b0 || m0_bus.rdata !== '0 || s_bus.addr !== '0 ||
            s_bus.wdata !== '0 || s_bus.wstrb !== '0 || s_bus.wr !== 1'b0 || s_bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_clear: got rv=%b rdata=%h addr=%h wdata=%h wstrb=%h wr=%b s_valid=%b, expected all 0",
                     m0_bus.rvalid, m0_bus.rdata, s_bus.addr, s_bus.wdata, s_bus.wstrb, s_bus.wr, s_bus.valid);
        end
        s_bus.rvalid = 1'b0;
        s_bus.rdata  = '0;
        step;
        reset_i = 1'b1;
        set_m0(1'b1, 32'hA00, 1'b0, '0, 4'h0);
        set_m1(1'b1, 32'hB00, 1'b0, '0, 4'h0);
        run_txn(0, 32'hA00, 1'b0, '0, 4'h0, 32'h0000_0A0A, 1'b0, "arst_tie0");
        run_txn(1, 32'hB00, 1'b0, '0, 4'h0, 32'h0000_0B0B, 1'b0, "arst_tie1");
    endtask

    task automatic test_spurious_rvalid;
        s_bus.rvalid = 1'b1;
        s_bus.rdata  = 32'h5555_5555;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({m1_bus.rvalid, m0_bus.rvalid} !== 2'b00 || m0_bus.rdata !== '0 ||
                m1_bus.rdata !== '0 || s_bus.valid !== 1'b0) begin
                errors++;
                $display("FAIL spurious: cycle %0d got rv{m1,m0}=%b rdata0=%h rdata1=%h s_valid=%b, expected 00 0 0 0",
                         k, {m1_bus.rvalid, m0_bus.rvalid}, m0_bus.rdata, m1_bus.rdata, s_bus.valid);
            end
            step;
        end
        s_bus.rvalid = 1'b0;
        s_bus.rdata  = '0;
        set_m1(1'b1, 32'hC00, 1'b0, '0, 4'h0);
        run_txn(1, 32'hC00, 1'b0, '0, 4'h0, 32'h0000_0C0C, 1'b0, "spurious_next");
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_tie_and_fairness;
        test_slave_stall;
        test_timeout_resp;
        test_timeout_req;
        test_async_reset;
        test_spurious_rvalid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tinymem_arbiter.md
Name: tinymem_arbiter

Overview:
- Two-requester arbiter that shares one downstream memory port between instruction fetch (m0) and data access (m1).
- Sits between the datapath fetch/load-store paths and the TileLink master memory controller.
- Round-robin fairness; one outstanding transaction at a time.
- Request capture, response routing and a response watchdog with error return.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width DATA_W/8
TIMEOUT, 256, max cycles in REQ+RESP before error completion; 0 disables the watchdog

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset
mN_valid_i  in  1  request valid, N in {0,1} (0=fetch, 1=data); held until mN_ready_o
mN_addr_i  in  ADDR_W  request address
mN_wr_i  in  1  1=write, 0=read
mN_wdata_i  in  DATA_W  write data
mN_wstrb_i  in  DATA_W/8  byte enables
mN_ready_o  out  1  request captured this cycle
mN_rvalid_o  out  1  response/ack valid, single-cycle pulse
mN_rdata_o  out  DATA_W  read data, valid with mN_rvalid_o
mN_err_o  out  1  response is a timeout error, valid with mN_rvalid_o
s_valid_o  out  1  downstream request valid
s_addr_o  out  ADDR_W  latched address
s_wr_o  out  1  latched write flag
s_wdata_o  out  DATA_W  latched write data
s_wstrb_o  out  DATA_W/8  latched strobes
s_ready_i  in  1  downstream accepts request
s_rvalid_i  in  1  downstream response/ack, one pulse per accepted request
s_rdata_i  in  DATA_W  downstream read data

Behaviour:
- Reset (reset_i=0, async):
  - state=IDLE, last_q=1, wait_cnt=0, latched request fields=0.
  - All outputs 0.
  - Any in-flight downstream transaction is abandoned.
- States: IDLE, REQ, RESP.
- IDLE, grant selection:
  - Only one valid: that requester is granted.
  - Both valid: grant = (last_q==1) ? 0 : 1, so m0 wins the first tie after reset.
  - Neither valid: stay in IDLE.
- IDLE, on grant:
  - mG_ready_o=1 combinationally in the same cycle.
  - Request fields latched; grant_q=G, last_q=G; go to REQ.
  - The non-granted mN_ready_o stays 0.
- REQ:
  - s_valid_o=1, driving the latched fields (stable while in REQ).
  - On s_ready_i=1, go to RESP.
- RESP:
  - On s_rvalid_i=1: m[grant_q]_rvalid_o=1 and m[grant_q]_rdata_o=s_rdata_i (combinational pass-through), err=0, go to IDLE.
  - Writes also complete via s_rvalid_i; rdata is don't-care for writes.
  - A response that coincides with a watchdog timeout is treated as normal completion.
- Output qualifiers: rdata/err outputs are 0 when not rvalid; a non-granted requester never sees rvalid.
- Latency:
  - Capture at cycle t; s_valid_o at t+1.
  - If s_ready_i at t+1 and s_rvalid_i at t+2, the requester sees rvalid at t+2.
  - The next capture is possible at t+3.
- Watchdog (TIMEOUT>0):
  - wait_cnt clears on entry to REQ and increments every cycle in REQ/RESP.
  - When wait_cnt==TIMEOUT-1 with no completion: m[grant_q]_rvalid_o=1, err=1, rdata=0; s_valid_o drops; go to IDLE.
  - Counter width $clog2(TIMEOUT+1).
- s_rvalid_i while in IDLE or REQ is ignored.
- Slave contract: no response is delivered after a timeout.
- Fairness: with continuous requests on both ports, grants alternate 0,1,0,1.
- A requester dropping valid before ready is a protocol violation; behaviour is undefined.

Decomposition:
- Package definitions:
  - arb_state_t enum {ARB_IDLE, ARB_REQ, ARB_RESP}.
  - mem_req_t packed struct {addr, wr, wdata, wstrb}, used for the latched request and the per-requester muxing.
- No sub-module: the 2-way round-robin pick is a few lines, kept inline.

Test Plan:
- Reset then m0 read 0x100 alone; slave ready at once, rvalid next cycle with 0xDEADBEEF -> m0_ready_o at t, s_valid_o at t+1 with addr 0x100, m0_rvalid_o at t+2 with rdata 0xDEADBEEF, m1 silent.
- Both valid same cycle after reset (m0 read 0x40, m1 write 0x80/0x12345678/wstrb 0xF) -> m0 granted first, m1 next; then both held valid for 4 transactions -> grant order 0,1,0,1.
- Slave holds s_ready_i low 5 cycles -> s_valid_o and fields stable 6 cycles, no ready/rvalid to either requester meanwhile.
- TIMEOUT=8, slave never responds to m1 read -> m1_rvalid_o=1, m1_err_o=1, rdata 0 exactly 8 cycles after REQ entry; arbiter back in IDLE and accepts m0 the next cycle.
- Assert reset_i low while in RESP -> outputs 0 immediately (async); after release, m0 wins the first tie.
- Spurious s_rvalid_i in IDLE -> no mN_rvalid_o; state unchanged.
